// File: rtl/sprite_pkg.sv
// ---------------------------------------------------------------------------
// sprite_pkg
//
// Purpose: shared definitions for the tile sprite renderer.
//   - color_t         : 24-bit RGB colour type
//   - TRANSP_IDX_DEF  : default palette index treated as transparent
//   - DEFAULT_PAL     : palette contents loaded while reset is asserted
//   - default_color() : reset colour for any palette entry (0 beyond the table)
//   - tile_art()      : built-in index image of the tile sheet
// ---------------------------------------------------------------------------
package sprite_pkg;

  localparam int COLOR_BITS = 24;
  typedef logic [COLOR_BITS-1:0] color_t;

  localparam int TRANSP_IDX_DEF = 0;

  localparam int DEFAULT_PAL_N = 9;

  // Entry 0 sits in the least significant slot.
  localparam logic [DEFAULT_PAL_N-1:0][COLOR_BITS-1:0] DEFAULT_PAL = {
    24'hE33F00,  // 8
    24'h756C5F,  // 7
    24'hAB3A00,  // 6
    24'hE6570C,  // 5
    24'hFFC89C,  // 4
    24'hFFFFEF,  // 3
    24'h0A0000,  // 2
    24'h888173,  // 1
    24'h800080   // 0
  };

  // Constant indices only, so the lookup stays a plain mux at elaboration.
  function automatic color_t default_color(input int unsigned idx);
    color_t c;
    c = '0;
    case (idx)
      0: c = DEFAULT_PAL[0];
      1: c = DEFAULT_PAL[1];
      2: c = DEFAULT_PAL[2];
      3: c = DEFAULT_PAL[3];
      4: c = DEFAULT_PAL[4];
      5: c = DEFAULT_PAL[5];
      6: c = DEFAULT_PAL[6];
      7: c = DEFAULT_PAL[7];
      8: c = DEFAULT_PAL[8];
      default: c = '0;
    endcase
    return c;
  endfunction

  // Index image of the tile sheet: a diagonal ramp through the nine
  // populated palette entries. x and y carry different weights so that
  // horizontal and vertical mirroring give distinct pixels.
  function automatic int unsigned tile_art(input int unsigned tile,
                                           input int unsigned x,
                                           input int unsigned y);
    return (5 * tile + x + 6 * y) % 9;
  endfunction

endpackage

// File: rtl/sprite_palette.sv
// ---------------------------------------------------------------------------
// sprite_palette
//
// Purpose: 2**IDX_W-entry colour register file. Every entry reloads its
// package default while reset is low. One write port, one registered read
// port; a read and a write to the same entry on the same edge return the
// colour held before that edge.
//
// Ports:
//   clk_i    in   1        clock, rising edge
//   rst_ni   in   1        asynchronous active-low reset
//   we_i     in   1        write strobe
//   waddr_i  in   IDX_W    write entry
//   wdata_i  in   COLOR_W  write colour
//   re_i     in   1        read enable (read register holds when low)
//   raddr_i  in   IDX_W    read entry
//   rdata_o  out  COLOR_W  registered read colour (0 during reset)
// ---------------------------------------------------------------------------
module sprite_palette
  import sprite_pkg::*;
#(
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 24
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic [IDX_W-1:0]   waddr_i,
  input  logic [COLOR_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [IDX_W-1:0]   raddr_i,
  output logic [COLOR_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [COLOR_W-1:0] entry [DEPTH];
  logic [COLOR_W-1:0] rdata_q;
  logic [COLOR_W-1:0] rdata_d;

  // One register per entry so each can carry its own reset colour.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [COLOR_W-1:0] entry_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_q <= COLOR_W'(default_color(gi));
      end else if (we_i && (waddr_i == IDX_W'(gi))) begin
        entry_q <= wdata_i;
      end
    end

    assign entry[gi] = entry_q;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = entry[raddr_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tile_sprite_rom.sv
// ---------------------------------------------------------------------------
// tile_sprite_rom
//
// Purpose: two-stage pixel fetch from a read-only tile sheet of palette
// indices followed by a palette lookup. Requests carry a tile number, pixel
// coordinates and mirror flags; each accepted request yields one coloured
// pixel two cycles later unless the output is back-pressured.
//
// Stage 1 registers the index memory read and an out-of-range flag.
// Stage 2 registers the palette colour and the transparency flags.
// The whole pipe advances together; it only freezes when a valid pixel is
// waiting at the output and downstream is not ready.
//
// Ports:
//   Clk         in   1        clock, rising edge
//   Reset_n     in   1        asynchronous active-low reset
//   req_valid   in   1        pixel request valid
//   req_ready   out  1        request accepted when req_valid && req_ready
//   req_tile    in   clog2(NUM_TILES)+1  tile number
//   req_x       in   clog2(TILE_W)       pixel column within tile
//   req_y       in   clog2(TILE_H)       pixel row within tile
//   req_flip_x  in   1        mirror horizontally
//   req_flip_y  in   1        mirror vertically
//   pix_valid   out  1        output pixel valid
//   pix_ready   in   1        downstream accepts pixel
//   pix_color   out  COLOR_W  palette colour (0 for out-of-range requests)
//   pix_transp  out  1        pixel is transparent
//   pal_we      in   1        palette write strobe
//   pal_waddr   in   IDX_W    palette write entry
//   pal_wdata   in   COLOR_W  palette write colour
// ---------------------------------------------------------------------------
module tile_sprite_rom
  import sprite_pkg::*;
#(
  parameter int    TILE_W     = 20,
  parameter int    TILE_H     = 20,
  parameter int    NUM_TILES  = 4,
  parameter int    IDX_W      = 4,
  parameter int    COLOR_W    = 24,
  parameter int    TRANSP_IDX = TRANSP_IDX_DEF,
  parameter string INIT_FILE  = "tiles.txt"
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(NUM_TILES):0]   req_tile,
  input  logic [$clog2(TILE_W)-1:0]    req_x,
  input  logic [$clog2(TILE_H)-1:0]    req_y,
  input  logic                         req_flip_x,
  input  logic                         req_flip_y,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [COLOR_W-1:0]           pix_color,
  output logic                         pix_transp,
  input  logic                         pal_we,
  input  logic [IDX_W-1:0]             pal_waddr,
  input  logic [COLOR_W-1:0]           pal_wdata
);

  localparam int T_W        = $clog2(NUM_TILES) + 1;
  localparam int X_W        = $clog2(TILE_W);
  localparam int Y_W        = $clog2(TILE_H);
  localparam int TILE_AREA  = TILE_W * TILE_H;
  localparam int DEPTH      = NUM_TILES * TILE_AREA;
  localparam int ADDR_W     = $clog2(DEPTH);

  localparam logic [IDX_W-1:0] TRANSP_IDX_L = IDX_W'(TRANSP_IDX);

  // -------------------------------------------------------------------------
  // Index image. It is generated from sprite_pkg::tile_art so the ROM
  // elaborates without a side file; an empty INIT_FILE selects a blank
  // sheet (every pixel index 0).
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] rom [DEPTH];

  if (INIT_FILE == "") begin : g_blank_sheet
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_px
      assign rom[gi] = '0;
    end
  end else begin : g_tile_art
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_px
      assign rom[gi] = IDX_W'(tile_art(gi / TILE_AREA,
                                       gi % TILE_W,
                                       (gi / TILE_W) % TILE_H));
    end
  end

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic              tile_ok;
  logic              x_ok;
  logic              y_ok;
  logic              in_range;
  logic [X_W-1:0]    x_eff;
  logic [Y_W-1:0]    y_eff;
  logic [ADDR_W-1:0] addr_calc;
  logic [ADDR_W-1:0] rom_addr;

  // Range checks are made on the raw coordinates, one bit wider than the
  // field so a power-of-two tile size compares correctly.
  assign tile_ok  = {1'b0, req_tile} < (T_W + 1)'(NUM_TILES);
  assign x_ok     = {1'b0, req_x}    < (X_W + 1)'(TILE_W);
  assign y_ok     = {1'b0, req_y}    < (Y_W + 1)'(TILE_H);
  assign in_range = tile_ok && x_ok && y_ok;

  assign x_eff = req_flip_x ? (X_W'(TILE_W - 1) - req_x) : req_x;
  assign y_eff = req_flip_y ? (Y_W'(TILE_H - 1) - req_y) : req_y;

  assign addr_calc = ADDR_W'(req_tile) * ADDR_W'(TILE_AREA)
                   + ADDR_W'(y_eff)    * ADDR_W'(TILE_W)
                   + ADDR_W'(x_eff);

  // Out-of-range requests still read memory; park the address at 0 so the
  // read never leaves the array. Their result is discarded downstream.
  assign rom_addr = in_range ? addr_calc : '0;

  // -------------------------------------------------------------------------
  // Flow control
  // -------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic oor1_q,     oor1_d;
  logic s2_valid_q, s2_valid_d;
  logic oor2_q,     oor2_d;
  logic tr2_q,      tr2_d;
  logic [IDX_W-1:0]   idx1_q;
  logic [COLOR_W-1:0] pal_rdata;
  logic               advance;
  logic               accept;

  // Only a valid pixel refused by downstream freezes the pipe. An empty
  // output stage therefore always lets stage 1 move forward.
  assign advance   = !(s2_valid_q && !pix_ready);
  assign req_ready = advance;
  assign accept    = req_valid && advance;

  always_comb begin
    s1_valid_d = s1_valid_q;
    oor1_d     = oor1_q;
    s2_valid_d = s2_valid_q;
    oor2_d     = oor2_q;
    tr2_d      = tr2_q;
    if (advance) begin
      s1_valid_d = accept;
      oor1_d     = accept && !in_range;
      s2_valid_d = s1_valid_q;
      oor2_d     = oor1_q;
      tr2_d      = s1_valid_q && !oor1_q && (idx1_q == TRANSP_IDX_L);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q <= 1'b0;
      oor1_q     <= 1'b0;
      s2_valid_q <= 1'b0;
      oor2_q     <= 1'b0;
      tr2_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      oor1_q     <= oor1_d;
      s2_valid_q <= s2_valid_d;
      oor2_q     <= oor2_d;
      tr2_q      <= tr2_d;
    end
  end

  // Index memory read port: registered, no reset, so it maps onto block RAM.
  always_ff @(posedge Clk) begin
    if (advance) begin
      idx1_q <= rom[rom_addr];
    end
  end

  // -------------------------------------------------------------------------
  // Palette (stage 2 lookup)
  // -------------------------------------------------------------------------
  sprite_palette #(
    .IDX_W   (IDX_W),
    .COLOR_W (COLOR_W)
  ) u_palette (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .we_i    (pal_we),
    .waddr_i (pal_waddr),
    .wdata_i (pal_wdata),
    .re_i    (advance),
    .raddr_i (idx1_q),
    .rdata_o (pal_rdata)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pix_valid  = s2_valid_q;
  assign pix_color  = oor2_q ? '0 : pal_rdata;
  assign pix_transp = oor2_q | tr2_q;

endmodule
